// File: rtl/sdram_req_bridge_pkg.sv
// Shared types and constants for the msx_slots -> SDRAM controller request bridge.
// Latency: n/a (types only). Backpressure: n/a.
package sdram_req_bridge_pkg;

    localparam int BRIDGE_AW           = 25;
    localparam int BRIDGE_DW           = 8;
    localparam int BRIDGE_BUSY_TIMEOUT = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } bridge_state_t;

    typedef struct packed {
        logic                 we;
        logic [BRIDGE_AW-1:0] addr;
        logic [BRIDGE_DW-1:0] din;
    } bridge_req_t;

endpackage

// File: rtl/sdram_req_detect.sv
// Turns level-held rd/we strobes into a one-cycle new_req plus the request to capture.
// Latency: combinational detect; served/key registered. Backpressure: none, downstream must absorb or drop.
module sdram_req_detect
    import sdram_req_bridge_pkg::*;
#(
    parameter int AW = BRIDGE_AW,
    parameter int DW = BRIDGE_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_din,
    input  logic          req_we,
    input  logic          req_rd,
    output logic          strobe,
    output logic          new_req,
    output bridge_req_t   det_req
);

    logic          served;
    logic          key_we;
    logic [AW-1:0] key_addr;

    // A held strobe re-triggers only if its address or kind moves away from the captured key.
    always_comb begin
        strobe  = req_we | req_rd;
        new_req = strobe && (!served || (req_addr != key_addr) || (req_we != key_we));
        det_req = '{we: req_we, addr: req_addr, din: req_din};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            served   <= 1'b0;
            key_we   <= 1'b0;
            key_addr <= '0;
        end else if (new_req) begin
            served   <= 1'b1;
            key_we   <= req_we;
            key_addr <= req_addr;
        end else if (!strobe) begin
            served   <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_req_bridge.sv
// Single-shot SDRAM request bridge with held read data, CPU wait and a one-deep pending slot.
// Latency: detect at cycle 0 -> mem_rd/mem_we at cycle 1; read data the cycle after mem_ready returns.
// Backpressure: cpu_wait stalls the CPU; a detect with the pending slot full is dropped (sticky overflow).
// Optional read cache: define SDRAM_REQ_BRIDGE_RDCACHE_EN.
module sdram_req_bridge
    import sdram_req_bridge_pkg::*;
#(
    parameter int AW = BRIDGE_AW,
    parameter int DW = BRIDGE_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_din,
    input  logic          req_we,
    input  logic          req_rd,
    output logic [DW-1:0] req_dout,
    output logic          cpu_wait,
    output logic          busy,
    output logic          overflow,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    output logic          mem_rd,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_dout
);

    localparam int TW = $clog2(BRIDGE_BUSY_TIMEOUT + 1);

    bridge_state_t state, state_nxt;
    bridge_req_t   det_req, act, pend;
    logic          strobe, new_req, hit;
    logic          pend_vld, wait_q, rd_vld;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] dout_q;
    logic [TW-1:0] tmo_cnt;
    logic          det_ok, done, start_idle, take_pend, direct, to_pend, drop, accepted;

    sdram_req_detect #(
        .AW (AW),
        .DW (DW)
    ) u_detect (
        .clk      (clk),
        .reset    (reset),
        .req_addr (req_addr),
        .req_din  (req_din),
        .req_we   (req_we),
        .req_rd   (req_rd),
        .strobe   (strobe),
        .new_req  (new_req),
        .det_req  (det_req)
    );

`ifdef SDRAM_REQ_BRIDGE_RDCACHE_EN
    // The last completed read address doubles as the cache tag; req_dout is the cached byte.
    assign hit = new_req && !det_req.we && rd_vld && (det_req.addr == rd_addr);
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        det_ok     = new_req && !hit;
        done       = mem_ready && ((state == WAIT_DONE) ||
                     ((state == WAIT_BUSY) && (tmo_cnt == TW'(BRIDGE_BUSY_TIMEOUT - 1))));
        start_idle = (state == IDLE) && mem_ready && (pend_vld || det_ok);
        take_pend  = pend_vld && (start_idle || done);
        direct     = start_idle && !pend_vld;
        to_pend    = det_ok && !direct;
        drop       = to_pend && pend_vld && !take_pend;
        accepted   = det_ok && !drop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start_idle) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!mem_ready) begin
                    state_nxt = WAIT_DONE;
                end else if (done) begin
                    state_nxt = pend_vld ? ISSUE : IDLE;
                end
            end
            WAIT_DONE: if (done) state_nxt = pend_vld ? ISSUE : IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // wait_q tracks the newest accepted request; it clears only when nothing newer sits in pending.
    always_comb begin
        mem_rd   = (state == ISSUE) && !act.we;
        mem_we   = (state == ISSUE) && act.we;
        busy     = (state != IDLE) || pend_vld;
        cpu_wait = !reset && strobe && (accepted || (wait_q && !(done && !pend_vld)));
    end

    assign mem_addr = act.addr;
    assign mem_din  = act.din;
    assign req_dout = dout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            act      <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
            tmo_cnt  <= '0;
            dout_q   <= '0;
            rd_addr  <= '0;
            rd_vld   <= 1'b0;
            overflow <= 1'b0;
            wait_q   <= 1'b0;
        end else begin
            if (take_pend) begin
                act <= pend;
            end else if (direct) begin
                act <= det_req;
            end
            if (to_pend && !drop) begin
                pend <= det_req;
            end
            pend_vld <= (pend_vld && !take_pend) || (to_pend && !drop);
            tmo_cnt  <= (state == WAIT_BUSY) ? tmo_cnt + 1'b1 : '0;
            // Writes to the last-read address keep req_dout coherent with memory.
            if (done && !act.we) begin
                dout_q  <= mem_dout;
                rd_addr <= act.addr;
                rd_vld  <= 1'b1;
            end else if ((state == ISSUE) && act.we && rd_vld && (act.addr == rd_addr)) begin
                dout_q  <= act.din;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (!strobe) begin
                wait_q <= 1'b0;
            end else if (accepted) begin
                wait_q <= 1'b1;
            end else if (done && !pend_vld) begin
                wait_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sdram_req_bridge.sv
// Scoreboard bench for sdram_req_bridge: behavioural controller, expected-request queue and memory-level reference model.
module tb_sdram_req_bridge;

    typedef struct packed {
        logic        we;
        logic [24:0] addr;
        logic [7:0]  din;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [24:0] req_addr = '0;
    logic [7:0]  req_din = '0;
    logic        req_we = 1'b0;
    logic        req_rd = 1'b0;
    logic [7:0]  req_dout;
    logic        cpu_wait, busy, overflow;
    logic [24:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we, mem_rd;
    logic        mem_ready = 1'b1;
    logic [7:0]  mem_dout = '0;

    int tests = 0;
    int fails = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;
    int busy_len = 3;
    int bcnt = 0;

    exp_t        exp_q[$];
    logic [7:0]  cmem [logic [24:0]];
    logic [7:0]  ref_mem [logic [24:0]];
    logic [7:0]  ref_dout = '0;
    logic [24:0] ref_rd_addr = '0;
    logic        ref_rd_vld = 1'b0;

    sdram_req_bridge dut (
        .clk       (clk),
        .reset     (reset),
        .req_addr  (req_addr),
        .req_din   (req_din),
        .req_we    (req_we),
        .req_rd    (req_rd),
        .req_dout  (req_dout),
        .cpu_wait  (cpu_wait),
        .busy      (busy),
        .overflow  (overflow),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_we    (mem_we),
        .mem_rd    (mem_rd),
        .mem_ready (mem_ready),
        .mem_dout  (mem_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_default(input logic [24:0] a);
        return a[7:0] ^ 8'h3C;
    endfunction

    // Controller model: accepts a strobe, then drops ready for busy_len cycles (0 = never drops).
    always @(posedge clk) begin
        if (mem_rd || mem_we) begin
            if (mem_we) cmem[mem_addr] = mem_din;
            else mem_dout <= cmem.exists(mem_addr) ? cmem[mem_addr] : mem_default(mem_addr);
            if (busy_len > 0) begin
                mem_ready <= 1'b0;
                bcnt = busy_len;
            end
        end else if (bcnt > 0) begin
            bcnt = bcnt - 1;
            if (bcnt == 0) mem_ready <= 1'b1;
        end
    end

    // Monitor: every controller strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (mem_rd || mem_we) begin
            if (mem_we) wr_pulses++;
            else rd_pulses++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL spurious_mem_req: got we=%b rd=%b addr=%h, required no request", mem_we, mem_rd, mem_addr);
            end else begin
                e = exp_q.pop_front();
                if (mem_we !== e.we || mem_rd !== !e.we || mem_addr !== e.addr || (e.we && mem_din !== e.din)) begin
                    fails++;
                    $display("FAIL mem_req: got we=%b rd=%b addr=%h din=%h, required we=%b addr=%h din=%h",
                             mem_we, mem_rd, mem_addr, mem_din, e.we, e.addr, e.din);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        tests++;
        if (act_v !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act_v, exp_v);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL %s: busy still 1 after %0d cycles, required 0", name, n);
        end
    endtask

    task automatic wait_cpu(input string name);
        int n = 0;
        while (cpu_wait && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (cpu_wait) begin
            tests++;
            fails++;
            $display("FAIL %s: cpu_wait still 1 after %0d cycles, required 0", name, n);
        end
    endtask

    // One CPU-style access: strobe held until cpu_wait falls; reference = byte memory + last-read address.
    task automatic cpu_access(input logic we, input logic [24:0] a, input logic [7:0] d);
        logic hit = 1'b0;
        logic fw;
`ifdef SDRAM_REQ_BRIDGE_RDCACHE_EN
        hit = !we && ref_rd_vld && (a == ref_rd_addr);
`endif
        if (!hit) exp_q.push_back('{we: we, addr: a, din: we ? d : 8'h00});
        if (we) begin
            ref_mem[a] = d;
            if (ref_rd_vld && a == ref_rd_addr) ref_dout = d;
        end else if (!hit) begin
            ref_dout    = ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
            ref_rd_addr = a;
            ref_rd_vld  = 1'b1;
        end
        @(posedge clk); #1;
        req_we = we; req_rd = !we; req_addr = a; req_din = d;
        @(negedge clk);
        fw = cpu_wait;
        chk("detect_cpu_wait", {31'd0, fw}, {31'd0, !hit});
        wait_cpu("access_cpu_wait");
        @(posedge clk); #1;
        req_we = 1'b0; req_rd = 1'b0;
        wait_idle("access_idle");
        chk("req_dout", {24'd0, req_dout}, {24'd0, ref_dout});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, w0;
        cmem[25'h01234] = 8'hA5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {req_dout, cpu_wait, busy, overflow, mem_we, mem_rd}, 32'd0);
        chk("rst_mem_bus", {mem_addr, mem_din}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Read with idle controller, 3-cycle busy.
        busy_len = 3; r0 = rd_pulses;
        exp_q.push_back('{we: 1'b0, addr: 25'h01234, din: 8'h00});
        @(posedge clk); #1;
        req_rd = 1'b1; req_addr = 25'h01234;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t1_cpu_wait", {31'd0, cpu_wait}, {31'd0, (c <= 4)});
            chk("t1_mem_rd", {31'd0, mem_rd}, {31'd0, (c == 1)});
            @(posedge clk); #1;
        end
        req_rd = 1'b0;
        wait_idle("t1_idle");
        chk("t1_req_dout", {24'd0, req_dout}, 32'hA5);
        chk("t1_rd_count", rd_pulses - r0, 1);

        // Back-to-back download writes: first issued, second held in pending.
        busy_len = 2; w0 = wr_pulses;
        exp_q.push_back('{we: 1'b1, addr: 25'h100, din: 8'h11});
        exp_q.push_back('{we: 1'b1, addr: 25'h101, din: 8'h22});
        @(posedge clk); #1;
        req_we = 1'b1; req_addr = 25'h100; req_din = 8'h11;
        @(posedge clk); #1;
        req_addr = 25'h101; req_din = 8'h22;
        @(posedge clk); #1;
        req_we = 1'b0;
        wait_idle("t2_idle");
        chk("t2_wr_count", wr_pulses - w0, 2);
        chk("t2_mem100", {24'd0, cmem[25'h100]}, 32'h11);
        chk("t2_mem101", {24'd0, cmem[25'h101]}, 32'h22);
        chk("t2_overflow", {31'd0, overflow}, 0);

        // Three writes while the controller stays busy: the third is dropped.
        busy_len = 20;
        exp_q.push_back('{we: 1'b1, addr: 25'h110, din: 8'h33});
        exp_q.push_back('{we: 1'b1, addr: 25'h111, din: 8'h44});
        @(posedge clk); #1;
        req_we = 1'b1; req_addr = 25'h110; req_din = 8'h33;
        @(posedge clk); #1;
        req_addr = 25'h111; req_din = 8'h44;
        @(posedge clk); #1;
        req_addr = 25'h112; req_din = 8'h55;
        @(posedge clk); #1;
        req_we = 1'b0;
        @(negedge clk);
        chk("t3_overflow_set", {31'd0, overflow}, 1);
        wait_idle("t3_idle");
        repeat (5) @(negedge clk);
        chk("t3_overflow_sticky", {31'd0, overflow}, 1);
        chk("t3_dropped_absent", {31'd0, cmem.exists(25'h112)}, 0);
        chk("t3_mem111", {24'd0, cmem[25'h111]}, 32'h44);

        // Address change under a held read strobe.
        busy_len = 1; r0 = rd_pulses;
        exp_q.push_back('{we: 1'b0, addr: 25'h200, din: 8'h00});
        exp_q.push_back('{we: 1'b0, addr: 25'h201, din: 8'h00});
        @(posedge clk); #1;
        req_rd = 1'b1; req_addr = 25'h200;
        @(negedge clk);
        wait_cpu("t4_first");
        @(posedge clk); #1;
        req_addr = 25'h201;
        @(negedge clk);
        wait_cpu("t4_second");
        @(posedge clk); #1;
        req_rd = 1'b0;
        wait_idle("t4_idle");
        chk("t4_rd_count", rd_pulses - r0, 2);
        chk("t4_req_dout", {24'd0, req_dout}, {24'd0, mem_default(25'h201)});

        // Reset while waiting for the controller to finish a read.
        busy_len = 10; r0 = rd_pulses;
        exp_q.push_back('{we: 1'b0, addr: 25'h500, din: 8'h00});
        @(posedge clk); #1;
        req_rd = 1'b1; req_addr = 25'h500;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("t5_busy_before_reset", {31'd0, busy}, 1);
        @(posedge clk); #1;
        req_rd = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t5_outputs_after_reset", {req_dout, cpu_wait, busy, overflow, mem_we, mem_rd}, 32'd0);
        chk("t5_mem_bus_after_reset", {mem_addr, mem_din}, 32'd0);
        repeat (20) @(negedge clk);
        chk("t5_no_reissue", rd_pulses - r0, 1);
        ref_dout = 8'h00; ref_rd_vld = 1'b0;

        // Repeated read, then write-then-read of the same address.
        busy_len = 2;
        cpu_access(1'b0, 25'h300, 8'h00);
        r0 = rd_pulses;
        cpu_access(1'b0, 25'h300, 8'h00);
`ifdef SDRAM_REQ_BRIDGE_RDCACHE_EN
        chk("t6_repeat_rd_count", rd_pulses - r0, 0);
`else
        chk("t6_repeat_rd_count", rd_pulses - r0, 1);
`endif
        cpu_access(1'b1, 25'h300, 8'h5A);
        cpu_access(1'b0, 25'h300, 8'h00);
        chk("t6_rd_after_wr", {24'd0, req_dout}, 32'h5A);

        // Random CPU accesses, including the stuck-ready timeout path (busy_len 0).
        for (int i = 0; i < 80; i++) begin
            logic        we;
            logic [24:0] a;
            logic [7:0]  d;
            busy_len = $urandom_range(0, 4);
            we = 1'($urandom_range(0, 1));
            a  = 25'h400 + 25'($urandom_range(0, 7));
            d  = 8'($urandom);
            cpu_access(we, a, d);
        end

        chk("queue_drained", exp_q.size(), 0);
        chk("final_overflow", {31'd0, overflow}, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
